mac_stop_mem: RTL and testbench
===============================

Name: mac_stop_mem

Overview:
- Operand and result storage for the MAC datapath: three independent register-file matrices.
  - A: M x K operand matrix.
  - B: K x N operand matrix.
  - C: M x N result matrix, wide enough to hold a K-term dot product.
- Each matrix has its own 2-D (row, col) address, synchronous write port and combinational read port.
- Host/testbench loads A, B and C and reads them back; the MAC engine uses the same ports.

Parameters:
- M, 4, rows of A and C.
- K, 4, columns of A and rows of B.
- N, 4, columns of B and C.
- DATA_WIDTH_INIT_MATRIX, 32, element width of A and B.
- DATA_WIDTH_RESULT_MATRIX, 2*DATA_WIDTH_INIT_MATRIX+$clog2(K) (=66), element width of C.

Ports:
- clk  in  1  single clock, all writes on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- data_in_a  in  DATA_WIDTH_INIT_MATRIX  write data for A.
- data_in_b  in  DATA_WIDTH_INIT_MATRIX  write data for B.
- data_in_c  in  DATA_WIDTH_RESULT_MATRIX  write data for C.
- row_addr_a  in  $clog2(M)  row index of A.
- col_addr_a  in  $clog2(K)  column index of A.
- row_addr_b  in  $clog2(K)  row index of B.
- col_addr_b  in  $clog2(N)  column index of B.
- row_addr_c  in  $clog2(M)  row index of C.
- col_addr_c  in  $clog2(N)  column index of C.
- matrix_a_we, matrix_b_we, matrix_c_we  in  1 each  write enables.
- matrix_a_re, matrix_b_re, matrix_c_re  in  1 each  read enables.
- data_out_a  out  DATA_WIDTH_INIT_MATRIX  read data for A.
- data_out_b  out  DATA_WIDTH_INIT_MATRIX  read data for B.
- data_out_c  out  DATA_WIDTH_RESULT_MATRIX  read data for C.

Behaviour:
- Storage: element (r,c) maps to flat index r*COLS+c within each matrix.
- Reset:
  - resetn low asynchronously clears every element of A, B and C to 0.
  - Clearing holds while resetn is low; writes are blocked during reset.
  - Reset asserted mid-write wins; that write is lost.
- Write:
  - On the rising edge of clk with we=1 and resetn=1, the addressed element takes data_in.
  - One-cycle latency; the value is readable immediately after that edge.
- Read:
  - Purely combinational. data_out_x = mem_x[row][col] when re_x=1, else 0.
  - Output must be valid within the same half cycle as the address/re change (bench samples at the following negedge).
- Read-during-write, same matrix and address: before the edge the output shows the old value; after the edge it shows the new value. No bypass.
- The three matrices are fully independent. Simultaneous accesses to different matrices never interact.
- we and re may both be high on one matrix.
- Out-of-range address (row>=ROWS or col>=COLS, possible with non-power-of-two dims):
  - Write is ignored.
  - Read returns 0.
- Write data is stored full width with no truncation. C stores its full 66 bits.
- With M=N=K=4, every address is in range and indices wrap naturally.

Optional Feature:
- Macro MAC_STOP_MEM_REG_OUT_EN.
- Defined:
  - Each data_out_x is registered on the rising edge of clk: loaded with mem[addr] when re=1, else holds its value.
  - Read latency is one cycle.
  - Output registers clear to 0 asynchronously on resetn low.
- Undefined (default): combinational reads as described above.

Decomposition:
- Package mac_stop_mem_pkg:
  - default M/K/N and data-width localparams;
  - address-width constants ($clog2 of each dim);
  - result-width function 2*W+$clog2(K).
- One natural sub-module mac_stop_mem_bank, parameterized (ROWS, COLS, WIDTH):
  - 2-D address, we/re, async clear, combinational or optional registered read.
- Top level instantiates the bank three times: A = M x K x 32, B = K x N x 32, C = M x N x 66.

Test Plan:
- Reset clear: pulse resetn low after arbitrary writes, then read all 48 elements with re=1 -> every data_out = 0.
- Write/readback A: write A = {{4,3,2,5},{3,4,5,2},{5,2,4,3},{2,5,3,4}} one element per cycle; read row-major, sampling at negedge -> A[0][0]=4, A[1][2]=5, A[3][3]=4.
- Write/readback B: write B = {{7,6,5,8},{6,7,8,5},{8,5,7,6},{5,8,6,7}} -> B[0][3]=8, B[2][1]=5, B[3][3]=7.
- Write/readback C: write C = {{87,95,88,94},{95,87,94,88},{94,88,87,95},{88,94,95,87}}, then write C[0][0]=2^65+3 -> C[1][0]=95, C[3][2]=95, C[0][0]=2^65+3 (full 66 bits retained).
- Gating and isolation:
  - re=0 -> data_out = 0 regardless of contents.
  - Writing A[2][2]=99 while reading B[2][2] -> data_out_b stays 7.
- Read-during-write at A[1][1] (holds 4), write 11 -> output 4 before the edge, 11 after it.
- With MAC_STOP_MEM_REG_OUT_EN defined, data appears one cycle after re/address are applied.

Source files
------------

// File: rtl/mac_stop_mem_pkg.sv
// mac_stop_mem_pkg: default matrix dimensions, element widths and address widths for the MAC operand/result store
package mac_stop_mem_pkg;
  localparam int M = 4;
  localparam int K = 4;
  localparam int N = 4;
  localparam int DATA_WIDTH_INIT = 32;
  localparam int M_AW = $clog2(M);
  localparam int K_AW = $clog2(K);
  localparam int N_AW = $clog2(N);
  function automatic int result_width(input int w, input int k);
    return 2 * w + $clog2(k);
  endfunction
  localparam int DATA_WIDTH_RESULT = result_width(DATA_WIDTH_INIT, K);
endpackage

// File: rtl/mac_stop_mem_bank.sv
// mac_stop_mem_bank: ROWS x COLS register-file matrix with async clear, sync write and gated read
// MAC_STOP_MEM_REG_OUT_EN selects a registered (one-cycle) read instead of the combinational one
module mac_stop_mem_bank #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int WIDTH = 32,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [RW-1:0]    row,
  input  logic [CW-1:0]    col,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);
  logic [WIDTH-1:0] mem [ROWS][COLS];
  logic             hit;
  logic [WIDTH-1:0] rd_data;
  // out-of-range addresses only exist for non-power-of-two dimensions
  assign hit = 32'(row) < ROWS && 32'(col) < COLS;
  assign rd_data = hit ? mem[row][col] : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mem <= '{default: '0};
    else if (we && hit) mem[row][col] <= data_in;
  end
`ifdef MAC_STOP_MEM_REG_OUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) data_out <= '0;
    else if (re) data_out <= rd_data;
  end
`else
  assign data_out = re ? rd_data : '0;
`endif
endmodule

// File: rtl/mac_stop_mem.sv
// mac_stop_mem: A (MxK), B (KxN) and C (MxN, dot-product width) storage banks for the MAC datapath
// MAC_STOP_MEM_REG_OUT_EN registers every read port
module mac_stop_mem import mac_stop_mem_pkg::*; #(
  parameter int M_DIM = M,
  parameter int K_DIM = K,
  parameter int N_DIM = N,
  parameter int DATA_WIDTH_INIT_MATRIX = DATA_WIDTH_INIT,
  parameter int DATA_WIDTH_RESULT_MATRIX = result_width(DATA_WIDTH_INIT_MATRIX, K_DIM),
  localparam int MA = M_DIM > 1 ? $clog2(M_DIM) : 1,
  localparam int KA = K_DIM > 1 ? $clog2(K_DIM) : 1,
  localparam int NA = N_DIM > 1 ? $clog2(N_DIM) : 1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
  input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
  input  logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
  input  logic [MA-1:0]                       row_addr_a,
  input  logic [KA-1:0]                       col_addr_a,
  input  logic [KA-1:0]                       row_addr_b,
  input  logic [NA-1:0]                       col_addr_b,
  input  logic [MA-1:0]                       row_addr_c,
  input  logic [NA-1:0]                       col_addr_c,
  input  logic                                matrix_a_we,
  input  logic                                matrix_b_we,
  input  logic                                matrix_c_we,
  input  logic                                matrix_a_re,
  input  logic                                matrix_b_re,
  input  logic                                matrix_c_re,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
  output logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
  output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_out_c
);
  mac_stop_mem_bank #(.ROWS(M_DIM), .COLS(K_DIM), .WIDTH(DATA_WIDTH_INIT_MATRIX)) u_a (
    .clk(clk), .resetn(resetn), .row(row_addr_a), .col(col_addr_a),
    .we(matrix_a_we), .re(matrix_a_re), .data_in(data_in_a), .data_out(data_out_a)
  );
  mac_stop_mem_bank #(.ROWS(K_DIM), .COLS(N_DIM), .WIDTH(DATA_WIDTH_INIT_MATRIX)) u_b (
    .clk(clk), .resetn(resetn), .row(row_addr_b), .col(col_addr_b),
    .we(matrix_b_we), .re(matrix_b_re), .data_in(data_in_b), .data_out(data_out_b)
  );
  mac_stop_mem_bank #(.ROWS(M_DIM), .COLS(N_DIM), .WIDTH(DATA_WIDTH_RESULT_MATRIX)) u_c (
    .clk(clk), .resetn(resetn), .row(row_addr_c), .col(col_addr_c),
    .we(matrix_c_we), .re(matrix_c_re), .data_in(data_in_c), .data_out(data_out_c)
  );
endmodule

// File: tb/tb_mac_stop_mem.sv
// tb_mac_stop_mem: directed load/readback of A, B, C with a queued expectation checked at each negedge
module tb_mac_stop_mem;
  logic        clk = 0;
  logic        resetn;
  logic [31:0] data_in_a, data_in_b, data_out_a, data_out_b;
  logic [65:0] data_in_c, data_out_c;
  logic [1:0]  row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c;
  logic        matrix_a_we, matrix_b_we, matrix_c_we, matrix_a_re, matrix_b_re, matrix_c_re;

  typedef struct {
    string       name;
    int          m;
    logic [65:0] v;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;

  int a_tab[4][4] = '{'{4,3,2,5}, '{3,4,5,2}, '{5,2,4,3}, '{2,5,3,4}};
  int b_tab[4][4] = '{'{7,6,5,8}, '{6,7,8,5}, '{8,5,7,6}, '{5,8,6,7}};
  int c_tab[4][4] = '{'{87,95,88,94}, '{95,87,94,88}, '{94,88,87,95}, '{88,94,95,87}};
  localparam logic [65:0] C_BIG = 66'h2_0000_0000_0000_0003;

  mac_stop_mem dut (
    .clk(clk), .resetn(resetn),
    .data_in_a(data_in_a), .data_in_b(data_in_b), .data_in_c(data_in_c),
    .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
    .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
    .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
    .matrix_a_we(matrix_a_we), .matrix_b_we(matrix_b_we), .matrix_c_we(matrix_c_we),
    .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re), .matrix_c_re(matrix_c_re),
    .data_out_a(data_out_a), .data_out_b(data_out_b), .data_out_c(data_out_c)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [65:0] act;
      e = q.pop_front();
      act = e.m == 0 ? {34'b0, data_out_a} : e.m == 1 ? {34'b0, data_out_b} : data_out_c;
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", e.name, act, e.v);
      end
    end
  end

  task automatic push(input string n, input int m, input logic [65:0] v);
    q.push_back('{n, m, v});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int m, input int r, input int c);
    case (m)
      0: begin row_addr_a = 2'(r); col_addr_a = 2'(c); end
      1: begin row_addr_b = 2'(r); col_addr_b = 2'(c); end
      default: begin row_addr_c = 2'(r); col_addr_c = 2'(c); end
    endcase
  endtask

  task automatic wr(input int m, input int r, input int c, input logic [65:0] d);
    set_addr(m, r, c);
    data_in_a = d[31:0];
    data_in_b = d[31:0];
    data_in_c = d;
    matrix_a_we = m == 0;
    matrix_b_we = m == 1;
    matrix_c_we = m == 2;
    tick();
    {matrix_a_we, matrix_b_we, matrix_c_we} = '0;
  endtask

  task automatic rd(input int m, input int r, input int c, input logic [65:0] v, input string n);
    set_addr(m, r, c);
    matrix_a_re = m == 0;
    matrix_b_re = m == 1;
    matrix_c_re = m == 2;
    push(n, m, v);
    tick();
    {matrix_a_re, matrix_b_re, matrix_c_re} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 0;
    {data_in_a, data_in_b, data_in_c} = '0;
    {row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c} = '0;
    {matrix_a_we, matrix_b_we, matrix_c_we, matrix_a_re, matrix_b_re, matrix_c_re} = '0;
    #12 resetn = 1;
    tick();
    rd(0, 1, 2, 0, "init_a");
    rd(1, 3, 0, 0, "init_b");
    rd(2, 2, 3, 0, "init_c");
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wr(0, r, c, 66'(a_tab[r][c]));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wr(1, r, c, 66'(b_tab[r][c]));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wr(2, r, c, 66'(c_tab[r][c]));
    wr(2, 0, 0, C_BIG);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) rd(0, r, c, 66'(a_tab[r][c]), $sformatf("a_%0d%0d", r, c));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) rd(1, r, c, 66'(b_tab[r][c]), $sformatf("b_%0d%0d", r, c));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        rd(2, r, c, (r == 0 && c == 0) ? C_BIG : 66'(c_tab[r][c]), $sformatf("c_%0d%0d", r, c));
    set_addr(0, 0, 0); set_addr(1, 0, 3); set_addr(2, 0, 0);
    push("gate_a", 0, 0); push("gate_b", 1, 0); push("gate_c", 2, 0);
    tick();
    set_addr(0, 2, 2); set_addr(1, 2, 2);
    data_in_a = 99; data_in_b = 123; matrix_a_we = 1; matrix_b_re = 1;
    push("iso_b_pre", 1, 7);
    tick();
    matrix_a_we = 0;
    push("iso_b_post", 1, 7);
    tick();
    matrix_b_re = 0;
    rd(0, 2, 2, 99, "iso_a");
    set_addr(0, 1, 1);
    data_in_a = 11; matrix_a_we = 1; matrix_a_re = 1;
    push("rdw_old", 0, 4);
    tick();
    matrix_a_we = 0;
    push("rdw_new", 0, 11);
    tick();
    matrix_a_re = 0;
    set_addr(0, 0, 0);
    data_in_a = 55; matrix_a_we = 1;
    #1 resetn = 0;
    tick();
    matrix_a_we = 0;
    rd(0, 0, 0, 0, "rst_hold_a");
    wr(0, 3, 3, 77);
    resetn = 1;
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) rd(m, r, c, 0, $sformatf("clr_%0d_%0d%0d", m, r, c));
    tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
